mul_booth_r4_iter: RTL and testbench
====================================

Name: mul_booth_r4_iter

Overview:
Parametrised iterative radix-4 Booth multiplier for the muldiv unit. It is the area-lean, width-generic successor of the 16-bit single-shot Booth/Wallace multiplier.
- Supports all four sign modes (uu/us/su/ss) and a half-width word mode (mulw).
- Retires two multiplier bits per cycle.
- Adds output back-pressure (out_ready) and flush.
- Sits beside the divider in the EXU muldiv path.

Parameters:
XLEN, 64, operand width; even, >= 8; full product is 2*XLEN bits.

Ports:
clk  input  1  clock, all state updates on posedge.
rst  input  1  synchronous, active-low reset (0 = reset, sampled on posedge clk).
mul_valid  input  1  request valid.
mul_ready  output  1  request accept; high only in IDLE.
flush  input  1  abort current operation; highest priority after reset.
mulw  input  1  word mode: operate on low XLEN/2 bits of each operand.
mul_signed  input  2  [1]=multiplicand signed, [0]=multiplier signed (00 uu, 01 us, 10 su, 11 ss).
multiplicand  input  XLEN  operand A.
multiplier  input  XLEN  operand B.
out_valid  output  1  result valid; held until out_ready.
out_ready  input  1  consumer accepts result.
result_hi  output  XLEN  upper half of product.
result_lo  output  XLEN  lower half of product.

Behaviour:
- Reset (rst=0 at posedge):
  - state=IDLE, out_valid=0, result_hi=result_lo=0, all internal registers cleared.
  - mul_ready=1 from the first cycle after reset.
  - Reset overrides everything, including an operation in flight.
- State machine IDLE -> BUSY -> DONE -> IDLE. mul_ready = (state==IDLE) and is combinational from state only.
- IDLE: on mul_valid&&mul_ready at edge e0:
  - Latch both operands, extended to XLEN+2 bits (sign-extend if the mode bit is set, else zero-extend).
  - Clear the accumulator and load the iteration counter with ITER.
  - ITER = XLEN/2+1; in mulw mode ITER = XLEN/4+1, using only the low XLEN/2 bits of each operand.
  - Go to BUSY.
- BUSY: each cycle takes one radix-4 Booth step.
  - Examine a 3-bit window of the multiplier and add 0/±M/±2M into the accumulator.
  - Arithmetic-shift the accumulator/multiplier pair right by 2.
  - Decrement the counter. When the counter reaches 1, the next edge moves to DONE and registers the result.
- Latency: out_valid rises ITER edges after e0. XLEN=64: 33 (mulw 17). XLEN=16: 9 (mulw 5).
- Result:
  - Normal mode: {result_hi,result_lo} = low 2*XLEN bits of the exact product for the selected sign mode.
  - mulw: product = low XLEN/2 bits of the (XLEN/2)x(XLEN/2) product; result_lo = that product sign-extended to XLEN; result_hi = replicated result_lo[XLEN-1]. mul_signed is ignored in mulw mode (always signed).
- DONE: out_valid=1 and results stable. On out_ready=1 at an edge, go to IDLE and clear out_valid.
  - result_hi/lo hold their last value until the next result is written.
  - A new request cannot be accepted in the same cycle as out_ready (mul_ready=0 in DONE).
- flush=1 at an edge in any state: go to IDLE, out_valid=0, counter cleared.
  - mul_valid in the same cycle as flush is ignored.
  - Results of a flushed operation are never presented.
- Operand inputs are don't-care outside the accept edge. Changes during BUSY must not affect the result.

Optional Feature:
MUL_ZERO_BYPASS_EN
- Defined: in IDLE, if the accepted multiplicand or multiplier is zero (after mulw masking), go directly to DONE with result 0. out_valid rises 1 edge after e0.
- Undefined: zero operands take the full ITER cycles and produce 0.
- Functional results are identical either way; only latency differs.

Decomposition:
- Shared package muldiv_pkg:
  - mul_signed encoding constants (MUL_UU=2'b00, MUL_US=2'b01, MUL_SU=2'b10, MUL_SS=2'b11).
  - FSM state encoding (IDLE/BUSY/DONE).
  - Helper function for the ITER computation; the divider reuses the same constants.
- One sub-module, booth_r4_sel: combinational 3-bit Booth decode plus ±1x/±2x multiplicand select (XLEN+3 bits wide). Also reused by the Wallace variant.

Test Plan:
- XLEN=16, ss: 0xFFFB * 0x0007 -> {hi,lo}=0xFFFF_FFDD; out_valid exactly 9 edges after accept; mul_ready low throughout.
- XLEN=16, all modes, A=0xFFFF B=0xFFFF -> uu 0xFFFE_0001, us/su 0xFFFF_0001, ss 0x0000_0001.
- XLEN=64, mulw=1, A=0x0000_0001_7FFF_FFFF B=2 -> result_lo=0xFFFF_FFFF_FFFF_FFFE, result_hi=all ones; latency 17.
- Back-pressure: hold out_ready=0 for 5 cycles after out_valid -> out_valid and result stay stable, mul_ready=0; raise out_ready -> IDLE next edge.
- flush 4 cycles into BUSY, then rst=0 mid-op on a second request -> IDLE, out_valid never asserts, next request (0x0080*0x007F) returns 0x0000_3F80 correctly.
- Full 16x16 cross of edge values {0,1,2,5,-1,0x80,0x7F,0xFF,-8,...} plus 20 random pairs, all four modes, vs. reference model; repeat with MUL_ZERO_BYPASS_EN defined (0*x latency 1).

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the EXU muldiv path (multiplier and divider).
//
// Contents:
//   MUL_UU/MUL_US/MUL_SU/MUL_SS  encodings of the 2-bit mul_signed field
//                                ([1] multiplicand signed, [0] multiplier signed)
//   muldiv_state_e               IDLE/BUSY/DONE sequencing states
//   booth_iter()                 number of radix-4 Booth steps for an operand width
package muldiv_pkg;

    localparam logic [1:0] MUL_UU = 2'b00;
    localparam logic [1:0] MUL_US = 2'b01;
    localparam logic [1:0] MUL_SU = 2'b10;
    localparam logic [1:0] MUL_SS = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } muldiv_state_e;

    // Operands are widened by two bits before recoding, so a full-width
    // operation needs XLEN/2+1 digits; word mode only needs enough digits to
    // cover the sign-extended half word.
    function automatic int booth_iter(input int xlen, input logic word);
        return word ? (xlen / 4 + 1) : (xlen / 2 + 1);
    endfunction

endpackage

// File: rtl/mul_booth_r4_iter_if.sv
// Request/response bundle of the iterative Booth multiplier.
//
// Signals:
//   mul_valid/mul_ready            request handshake
//   flush                          abort the operation in flight
//   mulw, mul_signed               operation mode
//   multiplicand, multiplier       operands (XLEN bits)
//   out_valid/out_ready            result handshake
//   result_hi, result_lo           product halves (XLEN bits each)
// Modports: master = requester side, slave = multiplier side.
interface mul_booth_r4_iter_if #(
    parameter int XLEN = 64
);
    logic            mul_valid;
    logic            mul_ready;
    logic            flush;
    logic            mulw;
    logic [1:0]      mul_signed;
    logic [XLEN-1:0] multiplicand;
    logic [XLEN-1:0] multiplier;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result_hi;
    logic [XLEN-1:0] result_lo;

    modport master (
        output mul_valid, flush, mulw, mul_signed, multiplicand, multiplier, out_ready,
        input  mul_ready, out_valid, result_hi, result_lo
    );

    modport slave (
        input  mul_valid, flush, mulw, mul_signed, multiplicand, multiplier, out_ready,
        output mul_ready, out_valid, result_hi, result_lo
    );
endinterface

// File: rtl/booth_r4_sel.sv
// Radix-4 Booth digit decode and partial-product select.
//
// Ports:
//   win    in   3        multiplier window {b[2i+1], b[2i], b[2i-1]}
//   mcand  in   XLEN+2   signed multiplicand
//   pp     out  XLEN+3   selected partial product: 0, +-M or +-2M
module booth_r4_sel #(
    parameter int XLEN = 64
) (
    input  logic [2:0]             win,
    input  logic signed [XLEN+1:0] mcand,
    output logic signed [XLEN+2:0] pp
);
    logic signed [XLEN+2:0] m1;
    logic signed [XLEN+2:0] m2;

    // One extra bit keeps 2M and -2M representable for any widened operand.
    assign m1 = {mcand[XLEN+1], mcand};
    assign m2 = {mcand, 1'b0};

    always_comb begin
        pp = '0;
        unique case (win)
            3'b001, 3'b010: pp = m1;
            3'b011:         pp = m2;
            3'b100:         pp = -m2;
            3'b101, 3'b110: pp = -m1;
            default:        pp = '0;
        endcase
    end
endmodule

// File: rtl/mul_booth_r4_iter.sv
// Iterative radix-4 Booth multiplier, two multiplier bits retired per cycle.
//
// Ports:
//   clk   in  clock, all state on posedge
//   rst   in  synchronous reset, active low
//   bus   mul_booth_r4_iter_if.slave: request, result and flush signals
//
// Operands are widened to XLEN+2 bits (sign or zero per mul_signed) so every
// sign mode runs through the same signed Booth datapath. Word mode (mulw)
// uses the low XLEN/2 bits of each operand, always signed, and returns the
// low half-word product sign-extended.
//
// Build option MUL_ZERO_BYPASS_EN: a zero operand finishes one edge after
// acceptance instead of taking the full iteration count.
module mul_booth_r4_iter
    import muldiv_pkg::*;
#(
    parameter int XLEN = 64
) (
    input logic                clk,
    input logic                rst,
    mul_booth_r4_iter_if.slave bus
);
    localparam int W      = XLEN + 2;          // widened operand
    localparam int AW     = XLEN + 4;          // accumulator, headroom for +-2M sums
    localparam int PW     = AW + W + 1;        // {acc, multiplier, b[-1]}
    localparam int HX     = XLEN / 2;
    localparam int ITER_F = booth_iter(XLEN, 1'b0);
    localparam int ITER_W = booth_iter(XLEN, 1'b1);
    localparam int CW     = $clog2(ITER_F + 1);
    // In word mode the product lands this many bits above the bottom of
    // {acc, multiplier} because fewer shifts have been applied.
    localparam int SH_W   = W - 2 * ITER_W;

    localparam logic [CW-1:0] ITER_F_C = CW'(ITER_F);
    localparam logic [CW-1:0] ITER_W_C = CW'(ITER_W);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    muldiv_state_e state;
    muldiv_state_e state_n;

    logic signed [AW-1:0]   acc;
    logic [W-1:0]           mq;
    logic                   bm1;
    logic signed [W-1:0]    mcand;
    logic                   mulw_q;
    logic [CW-1:0]          cnt;
    logic [XLEN-1:0]        res_hi;
    logic [XLEN-1:0]        res_lo;

    logic                   a_sgn;
    logic                   b_sgn;
    logic signed [W-1:0]    a_ext;
    logic signed [W-1:0]    b_ext;
    logic                   zero_op;
    logic                   accept;

    logic signed [W:0]      pp;
    logic signed [AW-1:0]   pp_ext;
    logic signed [AW-1:0]   acc_sum;
    logic signed [PW-1:0]   p_next;
    logic signed [HX-1:0]   wprod;

    // Operand widening
    assign a_sgn = !(bus.mul_signed == MUL_UU || bus.mul_signed == MUL_US);
    assign b_sgn = !(bus.mul_signed == MUL_UU || bus.mul_signed == MUL_SU);

    always_comb begin
        a_ext = '0;
        b_ext = '0;
        if (bus.mulw) begin
            a_ext = W'($signed(bus.multiplicand[HX-1:0]));
            b_ext = W'($signed(bus.multiplier[HX-1:0]));
        end else begin
            a_ext = $signed({{2{a_sgn & bus.multiplicand[XLEN-1]}}, bus.multiplicand});
            b_ext = $signed({{2{b_sgn & bus.multiplier[XLEN-1]}}, bus.multiplier});
        end
    end

`ifdef MUL_ZERO_BYPASS_EN
    assign zero_op = (a_ext == '0) || (b_ext == '0);
`else
    assign zero_op = 1'b0;
`endif

    assign accept = (state == IDLE) && bus.mul_valid;

    // Booth step
    booth_r4_sel #(.XLEN(XLEN)) u_sel (
        .win   ({mq[1:0], bm1}),
        .mcand (mcand),
        .pp    (pp)
    );

    assign pp_ext  = {{(AW - W - 1){pp[W]}}, pp};
    assign acc_sum = acc + pp_ext;
    assign p_next  = $signed({acc_sum, mq, bm1}) >>> 2;
    assign wprod   = p_next[SH_W + 1 +: HX];

    // Sequencing
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n       = state;
        bus.mul_ready = (state == IDLE);
        bus.out_valid = (state == DONE);
        if (bus.flush) begin
            state_n = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (bus.mul_valid) state_n = BUSY;
                BUSY:    if (cnt == CNT_ONE) state_n = DONE;
                DONE:    if (bus.out_ready) state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc    <= '0;
            mq     <= '0;
            bm1    <= 1'b0;
            mcand  <= '0;
            mulw_q <= 1'b0;
            cnt    <= '0;
            res_hi <= '0;
            res_lo <= '0;
        end else if (bus.flush) begin
            cnt <= '0;
        end else if (accept) begin
            // A zero-operand bypass runs a single step on cleared operands,
            // which yields a zero product one edge later in either mode.
            acc    <= '0;
            bm1    <= 1'b0;
            mcand  <= zero_op ? '0 : a_ext;
            mq     <= zero_op ? '0 : b_ext;
            mulw_q <= bus.mulw;
            cnt    <= zero_op ? CNT_ONE : (bus.mulw ? ITER_W_C : ITER_F_C);
        end else if (state == BUSY) begin
            acc <= p_next[PW-1:W+1];
            mq  <= p_next[W:1];
            bm1 <= p_next[0];
            cnt <= cnt - CNT_ONE;
            if (cnt == CNT_ONE) begin
                if (mulw_q) begin
                    res_lo <= XLEN'(wprod);
                    res_hi <= {XLEN{wprod[HX-1]}};
                end else begin
                    res_lo <= p_next[XLEN:1];
                    res_hi <= p_next[2*XLEN:XLEN+1];
                end
            end
        end
    end

    assign bus.result_hi = res_hi;
    assign bus.result_lo = res_lo;

endmodule

// File: tb/tb_mul_booth_r4_iter.sv
// Directed bench for mul_booth_r4_iter: a 16-bit instance for sign modes,
// latency, back-pressure, flush and reset, plus a 64-bit instance for word mode.
module tb_mul_booth_r4_iter;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mul_booth_r4_iter_if #(.XLEN(16)) b16 ();
    mul_booth_r4_iter_if #(.XLEN(64)) b64 ();

    mul_booth_r4_iter #(.XLEN(16)) dut16 (.clk(clk), .rst(rst), .bus(b16));
    mul_booth_r4_iter #(.XLEN(64)) dut64 (.clk(clk), .rst(rst), .bus(b64));

`ifdef MUL_ZERO_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref16(input logic [15:0] a, input logic [15:0] b,
                                         input logic [1:0] s);
        logic signed [63:0] ax;
        logic signed [63:0] bx;
        logic signed [63:0] p;
        ax = s[1] ? {{48{a[15]}}, a} : {48'd0, a};
        bx = s[0] ? {{48{b[15]}}, b} : {48'd0, b};
        p  = ax * bx;
        return p[31:0];
    endfunction

    function automatic int lat16(input logic [15:0] a, input logic [15:0] b, input logic w);
        logic z;
        z = w ? (a[7:0] == 8'd0 || b[7:0] == 8'd0) : (a == 16'd0 || b == 16'd0);
        if (BYPASS && z) return 1;
        return w ? 5 : 9;
    endfunction

    // One request on the 16-bit instance; operands are scrambled right after
    // acceptance, and mul_ready is watched until out_valid appears.
    task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic [1:0] s,
                         input logic w, output logic [31:0] prod, output int lat,
                         output logic busy_ok);
        int guard;
        guard = 0;
        while (!b16.mul_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        b16.multiplicand = a;
        b16.multiplier   = b;
        b16.mul_signed   = s;
        b16.mulw         = w;
        b16.mul_valid    = 1'b1;
        @(posedge clk); #1;
        b16.mul_valid    = 1'b0;
        b16.multiplicand = 16'($urandom);
        b16.multiplier   = 16'($urandom);
        b16.mul_signed   = 2'($urandom);
        b16.mulw         = 1'($urandom);
        lat     = 0;
        busy_ok = 1'b1;
        while (!b16.out_valid && lat < 100) begin
            if (b16.mul_ready) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        prod = {b16.result_hi, b16.result_lo};
        b16.out_ready = 1'b1;
        @(posedge clk); #1;
        b16.out_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] prod;
        logic [31:0] snap;
        int          lat;
        logic        busy_ok;
        logic        seen;
        logic [15:0] ev [11];
        logic [15:0] ra;
        logic [15:0] rb;

        ev = '{16'h0000, 16'h0001, 16'h0002, 16'h0005, 16'hFFFF, 16'h0080,
               16'h007F, 16'h00FF, 16'hFFF8, 16'h8000, 16'h7FFF};

        rst = 1'b0;
        b16.mul_valid = 1'b0; b16.flush = 1'b0; b16.mulw = 1'b0; b16.mul_signed = MUL_UU;
        b16.multiplicand = '0; b16.multiplier = '0; b16.out_ready = 1'b0;
        b64.mul_valid = 1'b0; b64.flush = 1'b0; b64.mulw = 1'b0; b64.mul_signed = MUL_UU;
        b64.multiplicand = '0; b64.multiplier = '0; b64.out_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(b16.out_valid), 64'(1'b0));
        check("rst_result", 64'({b16.result_hi, b16.result_lo}), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_ready16", 64'(b16.mul_ready), 64'(1'b1));
        check("rst_ready64", 64'(b64.mul_ready), 64'(1'b1));

        // Signed small product, exact latency, ready low while busy
        run16(16'hFFFB, 16'h0007, MUL_SS, 1'b0, prod, lat, busy_ok);
        check("ss_prod", 64'(prod), 64'(32'hFFFF_FFDD));
        check("ss_lat", 64'(lat), 64'd9);
        check("ss_ready_low", 64'(busy_ok), 64'(1'b1));

        // All-ones operands in each sign mode
        run16(16'hFFFF, 16'hFFFF, MUL_UU, 1'b0, prod, lat, busy_ok);
        check("ones_uu", 64'(prod), 64'(32'hFFFE_0001));
        run16(16'hFFFF, 16'hFFFF, MUL_US, 1'b0, prod, lat, busy_ok);
        check("ones_us", 64'(prod), 64'(32'hFFFF_0001));
        run16(16'hFFFF, 16'hFFFF, MUL_SU, 1'b0, prod, lat, busy_ok);
        check("ones_su", 64'(prod), 64'(32'hFFFF_0001));
        run16(16'hFFFF, 16'hFFFF, MUL_SS, 1'b0, prod, lat, busy_ok);
        check("ones_ss", 64'(prod), 64'(32'h0000_0001));

        // Word mode on 16 bits: low bytes 0xFF * 0x03 = -3, mul_signed ignored
        run16(16'h01FF, 16'h0003, MUL_UU, 1'b1, prod, lat, busy_ok);
        check("w16_prod", 64'(prod), 64'(32'hFFFF_FFFD));
        check("w16_lat", 64'(lat), 64'd5);

        // Word mode on 64 bits
        b64.multiplicand = 64'h0000_0001_7FFF_FFFF;
        b64.multiplier   = 64'd2;
        b64.mulw         = 1'b1;
        b64.mul_signed   = MUL_UU;
        b64.mul_valid    = 1'b1;
        @(posedge clk); #1;
        b64.mul_valid    = 1'b0;
        b64.multiplicand = 64'hDEAD_BEEF_0000_0000;
        lat = 0;
        while (!b64.out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("w64_lo", b64.result_lo, 64'hFFFF_FFFF_FFFF_FFFE);
        check("w64_hi", b64.result_hi, 64'hFFFF_FFFF_FFFF_FFFF);
        check("w64_lat", 64'(lat), 64'd17);
        b64.out_ready = 1'b1;
        @(posedge clk); #1;
        b64.out_ready = 1'b0;

        // Back-pressure: 3 * -4 held for five cycles
        b16.multiplicand = 16'h0003; b16.multiplier = 16'hFFFC;
        b16.mul_signed = MUL_SS; b16.mulw = 1'b0; b16.mul_valid = 1'b1;
        @(posedge clk); #1;
        b16.mul_valid = 1'b0;
        lat = 0;
        while (!b16.out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        snap = {b16.result_hi, b16.result_lo};
        check("bp_prod", 64'(snap), 64'(32'hFFFF_FFF4));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_valid_held", 64'(b16.out_valid), 64'(1'b1));
            check("bp_result_held", 64'({b16.result_hi, b16.result_lo}), 64'(32'hFFFF_FFF4));
            check("bp_ready_low", 64'(b16.mul_ready), 64'(1'b0));
        end
        b16.out_ready = 1'b1;
        @(posedge clk); #1;
        b16.out_ready = 1'b0;
        check("bp_release_valid", 64'(b16.out_valid), 64'(1'b0));
        check("bp_release_ready", 64'(b16.mul_ready), 64'(1'b1));
        check("bp_result_kept", 64'({b16.result_hi, b16.result_lo}), 64'(32'hFFFF_FFF4));

        // Flush four cycles into BUSY, with a request offered in the flush cycle
        b16.multiplicand = 16'h1234; b16.multiplier = 16'h0567;
        b16.mul_signed = MUL_SS; b16.mul_valid = 1'b1;
        @(posedge clk); #1;
        b16.mul_valid = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        check("fl_busy", 64'(b16.mul_ready), 64'(1'b0));
        b16.flush = 1'b1; b16.mul_valid = 1'b1;
        @(posedge clk); #1;
        b16.flush = 1'b0; b16.mul_valid = 1'b0;
        check("fl_ready", 64'(b16.mul_ready), 64'(1'b1));
        check("fl_valid", 64'(b16.out_valid), 64'(1'b0));
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (b16.out_valid) seen = 1'b1;
        end
        check("fl_no_result", 64'(seen), 64'(1'b0));

        // Reset in the middle of a second request
        b16.multiplicand = 16'h00FF; b16.multiplier = 16'h00FF; b16.mul_valid = 1'b1;
        @(posedge clk); #1;
        b16.mul_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        check("mrst_ready", 64'(b16.mul_ready), 64'(1'b1));
        check("mrst_valid", 64'(b16.out_valid), 64'(1'b0));
        check("mrst_result", 64'({b16.result_hi, b16.result_lo}), 64'd0);
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (b16.out_valid) seen = 1'b1;
        end
        check("mrst_no_result", 64'(seen), 64'(1'b0));
        run16(16'h0080, 16'h007F, MUL_SS, 1'b0, prod, lat, busy_ok);
        check("after_rst_prod", 64'(prod), 64'(32'h0000_3F80));
        check("after_rst_lat", 64'(lat), 64'd9);

        // Edge-value cross in every sign mode
        for (int s = 0; s < 4; s++) begin
            for (int i = 0; i < 11; i++) begin
                for (int j = 0; j < 11; j++) begin
                    run16(ev[i], ev[j], 2'(s), 1'b0, prod, lat, busy_ok);
                    check("cross_prod", 64'(prod), 64'(ref16(ev[i], ev[j], 2'(s))));
                    check("cross_lat", 64'(lat), 64'(lat16(ev[i], ev[j], 1'b0)));
                end
            end
        end

        // Random pairs in every sign mode
        for (int k = 0; k < 20; k++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            for (int s = 0; s < 4; s++) begin
                run16(ra, rb, 2'(s), 1'b0, prod, lat, busy_ok);
                check("rand_prod", 64'(prod), 64'(ref16(ra, rb, 2'(s))));
            end
        end

        // Zero in word mode: masked low byte is zero
        run16(16'h3400, 16'h0005, MUL_SS, 1'b1, prod, lat, busy_ok);
        check("wzero_prod", 64'(prod), 64'd0);
        check("wzero_lat", 64'(lat), 64'(lat16(16'h3400, 16'h0005, 1'b1)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
